fetch_decode_reg: RTL
=====================

Name: fetch_decode_reg

Overview:
- Pipeline boundary between the fetch stage and the decode stage.
- Captures the fetched instruction and its PC+4 into a 2-entry skid buffer, and presents the oldest entry to decode with a valid/ready handshake.
- Breaks the combinational path from the decode stall to the fetch PC enable, and squashes wrong-path instructions on a taken branch or jump.

Parameters:
- WIDTH, 32, width of the instruction and PC words.
- NOP_INSTR, 32'h00000000, value driven on instr_d when no valid entry is held (sll $0,$0,0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_f  input  1  fetch presents a valid instruction this cycle.
- instr_f  input  WIDTH  fetched instruction.
- pc_plus_4_f  input  WIDTH  PC+4 of the fetched instruction.
- ready_f  output  1  buffer can accept; fetch advances its PC register only when high.
- flush_d  input  1  squash all held and incoming instructions (taken branch, j, jal, jr resolved in decode).
- ready_d  input  1  decode accepts the head entry this cycle.
- valid_d  output  1  head entry is valid.
- instr_d  output  WIDTH  head instruction, or NOP_INSTR when valid_d=0.
- pc_plus_4_d  output  WIDTH  head PC+4, or 0 when valid_d=0.

Behaviour:
- Storage:
  - Two entries (slot0 = head, slot1 = tail) holding {instr, pc_plus_4}.
  - count is 2 bits, range 0..2.
- Output timing:
  - Outputs come directly from slot0 and count; no combinational path from any input to any output.
  - ready_f = (count != 2), decoded from registered count only; independent of ready_d in the same cycle.
- Transfers:
  - push = valid_f & ready_f.
  - pop = valid_d & ready_d.
- Latency: an entry pushed at edge N appears on instr_d/pc_plus_4_d with valid_d=1 after edge N, provided no older entry is pending.
- Ordering: strict FIFO; instructions are never dropped except by flush_d or reset; never duplicated.
- Count/slot rules per edge (no flush):
  - count 0: push → slot0 = input, count 1.
  - count 1: push only → slot1 = input, count 2. pop only → count 0. push & pop → slot0 = input, count 1.
  - count 2: no push possible. pop → slot0 = slot1, count 1.
- Flush:
  - flush_d=1 at an edge sets count 0, valid_d 0.
  - Any simultaneous push is discarded.
  - Flush beats push and pop.
  - The instruction in decode during the flush cycle is the delay-slot/branch instruction; decode consumes it itself. Discarding the pop is harmless.
- Empty output values: valid_d=0, instr_d=NOP_INSTR, pc_plus_4_d=0. Slot contents are don't-care internally but must not leak to the outputs.
- Reset:
  - reset=1 at an edge sets count 0, valid_d 0, instr_d NOP_INSTR, pc_plus_4_d 0, ready_f 1 after the edge.
  - Reset beats flush, push and pop.
  - Reset asserted mid-stream discards all entries; the first push after reset deasserts is handled as from empty.
- X-safety: slot registers load only on push or shift; when valid_d=0 the outputs are forced to their empty values.

Optional Feature:
- Macro: FETCH_DECODE_PERF_EN.
- With the macro defined, two extra output ports are added:
  - stall_cnt (32): counts cycles with valid_d=1 and ready_d=0.
  - flush_cnt (32): counts edges where flush_d=1 and count!=0 or push was attempted.
  - Both counters are cleared by reset and wrap modulo 2^32.
- Without the macro: no extra ports or registers; behaviour is otherwise identical.

Test Plan:
1. Reset then stream: reset 2 cycles, then valid_f=1, ready_d=1 with instr_f 0x20080005, 0x20090003, 0x01095020 on consecutive cycles → instr_d shows each one cycle later in order, valid_d=1 continuously, ready_f stays 1.
2. Decode stall: push 0x8C080000 and 0x8C090004, ready_d=0 → count 2, ready_f=0, instr_d holds 0x8C080000. Raise ready_d → 0x8C090004 next cycle, ready_f=1 again.
3. Flush with push: count 1 holding 0x10000003, flush_d=1, valid_f=1 instr_f 0xAC0A0008 → after edge valid_d=0, instr_d=0x00000000, pc_plus_4_d=0. Next push appears normally.
4. Simultaneous push/pop at count 1: head 0x00000020, push 0x00000021 with ready_d=1 → instr_d=0x00000021, count stays 1, no entry lost.
5. Reset mid-stream: count 2, assert reset alongside flush_d=0, valid_f=1 → all outputs at reset values, ready_f=1. First post-reset instruction appears one cycle after push.
6. With FETCH_DECODE_PERF_EN: 3 stalled cycles plus 1 non-empty flush → stall_cnt=3, flush_cnt=1. Reset clears both to 0.

Source files
------------

// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: 2-entry skid buffer between fetch and decode with flush squash.
// Define FETCH_DECODE_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module fetch_decode_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_f,
    input  logic [WIDTH-1:0] instr_f,
    input  logic [WIDTH-1:0] pc_plus_4_f,
    output logic             ready_f,
    input  logic             flush_d,
    input  logic             ready_d,
    output logic             valid_d,
    output logic [WIDTH-1:0] instr_d,
    output logic [WIDTH-1:0] pc_plus_4_d
`ifdef FETCH_DECODE_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);
    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_instr0, r_pc0, r_instr1, r_pc1;
    logic             w_push, w_pop, w_ld0, w_ld1, w_full;

    assign w_full      = r_count == 2'd2;
    assign ready_f     = ~w_full;
    assign valid_d     = r_count != 2'd0;
    assign instr_d     = valid_d ? r_instr0 : NOP_INSTR;
    assign pc_plus_4_d = valid_d ? r_pc0 : '0;
    assign w_push      = valid_f & ready_f;
    assign w_pop       = valid_d & ready_d;
    // head takes the input when empty or draining, the tail when a full buffer pops
    assign w_ld0       = (w_push & (~valid_d | w_pop)) | (w_pop & w_full);
    assign w_ld1       = w_push & valid_d & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset || flush_d)
            r_count <= 2'd0;
        else if (w_push && !w_pop)
            r_count <= r_count + 2'd1;
        else if (w_pop && !w_push)
            r_count <= r_count - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (w_ld0) begin
            r_instr0 <= w_full ? r_instr1 : instr_f;
            r_pc0    <= w_full ? r_pc1 : pc_plus_4_f;
        end
        if (w_ld1) begin
            r_instr1 <= instr_f;
            r_pc1    <= pc_plus_4_f;
        end
    end

`ifdef FETCH_DECODE_PERF_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (valid_d && !ready_d)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush_d && (valid_d || valid_f))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end
`endif
endmodule
